// File: rtl/cv32e40x_instr_aligner.sv
`default_nettype none
// ============================================================================
//  Module   : cv32e40x_instr_aligner
//  Purpose  : Buffers word-aligned fetch data and emits one 16/32-bit
//             instruction per handshake, with its PC and bus-error flag.
//  Revision : 1.0  initial release
// ============================================================================
module cv32e40x_instr_aligner #(
    parameter int DEPTH = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    input  logic        fetch_err_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_compressed_o,
    output logic        instr_err_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]    data_q [DEPTH];
    logic [DEPTH-1:0] err_q;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, nxt_ptr;
    logic [CW-1:0]  count_q, count_d;
    logic           hw_sel_q, hw_sel_d;
    logic [31:0]    pc_q, pc_d;

    logic [31:0]    head, next, rdata;
    logic           head_err, next_err, req, cmp, err;
    logic           push, pop, pop_word;
    logic           unused_addr_bit;

    assign unused_addr_bit = branch_addr_i[0];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign nxt_ptr  = ptr_inc(rd_ptr_q);
    assign head     = data_q[rd_ptr_q];
    assign head_err = err_q[rd_ptr_q];
    assign next     = data_q[nxt_ptr];
    assign next_err = err_q[nxt_ptr];

    always_comb begin
        req   = 1'b0;
        cmp   = 1'b0;
        err   = 1'b0;
        rdata = '0;
        if (!hw_sel_q) begin
            req = (count_q != '0);
            if (head_err) begin
                err = 1'b1;
            end else if (head[1:0] != 2'b11) begin
                cmp   = 1'b1;
                rdata = {16'h0, head[15:0]};
            end else begin
                rdata = head;
            end
        end else if (head_err) begin
            req = (count_q != '0);
            err = 1'b1;
        end else if (head[17:16] != 2'b11) begin
            req   = (count_q != '0);
            cmp   = 1'b1;
            rdata = {16'h0, head[31:16]};
        end else begin
            // Straddling instruction: upper half of head plus lower half of next
            req = (count_q >= CW'(2));
            if (next_err) begin
                err = 1'b1;
            end else begin
                rdata = {next[15:0], head[31:16]};
            end
        end
    end

    assign fetch_ready_o      = (count_q < CW'(DEPTH));
    assign instr_valid_o      = req && !branch_i;
    assign instr_rdata_o      = req ? rdata : 32'h0;
    assign instr_compressed_o = req && cmp;
    assign instr_err_o        = req && err;
    assign instr_pc_o         = pc_q;

    assign push     = fetch_valid_i && fetch_ready_o && !branch_i;
    assign pop      = instr_valid_o && instr_ready_i;
    // A compressed instruction in the low half leaves the word in place
    assign pop_word = pop && (hw_sel_q || !cmp);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        hw_sel_d = hw_sel_q;
        pc_d     = pc_q;
        if (branch_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            hw_sel_d = branch_addr_i[1];
            pc_d     = {branch_addr_i[31:1], 1'b0};
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop_word) begin
                rd_ptr_d = nxt_ptr;
            end
            count_d = count_q + CW'(push) - CW'(pop_word);
            if (pop) begin
                pc_d     = pc_q + (cmp ? 32'd2 : 32'd4);
                hw_sel_d = hw_sel_q ? !cmp : cmp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            hw_sel_q <= 1'b0;
            pc_q     <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            hw_sel_q <= hw_sel_d;
            pc_q     <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= fetch_rdata_i;
            err_q[wr_ptr_q]  <= fetch_err_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cv32e40x_instr_aligner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cv32e40x_instr_aligner
//  Purpose  : Directed and random checks of the aligner against a halfword
//             stream model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cv32e40x_instr_aligner;

    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid_i, fetch_err_i, branch_i, instr_ready_i;
    logic [31:0] fetch_rdata_i, branch_addr_i;
    logic        fetch_ready_o, instr_valid_o, instr_compressed_o, instr_err_o;
    logic [31:0] instr_rdata_o, instr_pc_o;

    always #5 clk = ~clk;

    cv32e40x_instr_aligner #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .fetch_valid_i      (fetch_valid_i),
        .fetch_ready_o      (fetch_ready_o),
        .fetch_rdata_i      (fetch_rdata_i),
        .fetch_err_i        (fetch_err_i),
        .branch_i           (branch_i),
        .branch_addr_i      (branch_addr_i),
        .instr_valid_o      (instr_valid_o),
        .instr_ready_i      (instr_ready_i),
        .instr_rdata_o      (instr_rdata_o),
        .instr_pc_o         (instr_pc_o),
        .instr_compressed_o (instr_compressed_o),
        .instr_err_o        (instr_err_o)
    );

    // Model: queue of buffered words {err, data} and halfword offset into head
    logic [32:0] wq[$];
    int          moff;
    logic [31:0] mpc;
    logic        e_valid, e_cmp, e_err;
    logic [31:0] e_rdata;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] hw_at(input int idx);
        logic [32:0] w;
        w = wq[idx / 2];
        return (idx % 2 == 0) ? w[15:0] : w[31:16];
    endfunction

    task automatic model_eval();
        logic [15:0] lo;
        e_valid = 1'b0; e_cmp = 1'b0; e_err = 1'b0; e_rdata = 32'h0;
        if (wq.size() > 0) begin
            lo = hw_at(moff);
            if (wq[0][32]) begin
                e_valid = 1'b1; e_err = 1'b1;
            end else if (lo[1:0] != 2'b11) begin
                e_valid = 1'b1; e_cmp = 1'b1; e_rdata = {16'h0, lo};
            end else if (moff + 2 <= 2 * wq.size()) begin
                e_valid = 1'b1;
                if (wq[(moff + 1) / 2][32]) e_err = 1'b1;
                else e_rdata = {hw_at(moff + 1), lo};
            end
        end
    endtask

    task automatic step(input logic fv, input logic [31:0] fd, input logic fe,
                        input logic br, input logic [31:0] ba, input logic rdy);
        logic e_ready, e_v;
        int   pos;
        @(negedge clk);
        rst = 1'b0; fetch_valid_i = fv; fetch_rdata_i = fd; fetch_err_i = fe;
        branch_i = br; branch_addr_i = ba; instr_ready_i = rdy;
        #1;
        model_eval();
        e_ready = (wq.size() < DEPTH);
        e_v     = e_valid && !br;
        chk("fetch_ready", {31'h0, fetch_ready_o}, {31'h0, e_ready});
        chk("instr_valid", {31'h0, instr_valid_o}, {31'h0, e_v});
        chk("instr_pc", instr_pc_o, mpc);
        if (e_v) begin
            chk("instr_rdata", instr_rdata_o, e_rdata);
            chk("instr_compressed", {31'h0, instr_compressed_o}, {31'h0, e_cmp});
            chk("instr_err", {31'h0, instr_err_o}, {31'h0, e_err});
        end
        @(posedge clk);
        if (br) begin
            wq.delete();
            mpc  = {ba[31:1], 1'b0};
            moff = ba[1] ? 1 : 0;
        end else begin
            if (e_v && rdy) begin
                mpc = mpc + (e_cmp ? 32'd2 : 32'd4);
                pos = moff + (e_cmp ? 1 : 2);
                while (pos >= 2) begin
                    void'(wq.pop_front());
                    pos -= 2;
                end
                moff = pos;
            end
            if (fv && e_ready) wq.push_back({fe, fd});
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, rdy);
    endtask

    task automatic push(input logic [31:0] d, input logic e, input logic rdy);
        step(1'b1, d, e, 1'b0, 32'h0, rdy);
    endtask

    task automatic branch(input logic [31:0] a);
        step(1'b0, 32'h0, 1'b0, 1'b1, a, 1'b0);
    endtask

    initial begin
        rst = 1'b1; fetch_valid_i = 1'b1; fetch_rdata_i = 32'h00B50533; fetch_err_i = 1'b0;
        branch_i = 1'b1; branch_addr_i = 32'h40; instr_ready_i = 1'b1;
        wq.delete(); moff = 0; mpc = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; fetch_valid_i = 1'b0; branch_i = 1'b0; instr_ready_i = 1'b0;
        #1;
        chk("rst_fetch_ready", {31'h0, fetch_ready_o}, 32'h1);
        chk("rst_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("rst_rdata", instr_rdata_o, 32'h0);
        chk("rst_pc", instr_pc_o, 32'h0);
        chk("rst_compressed", {31'h0, instr_compressed_o}, 32'h0);
        chk("rst_err", {31'h0, instr_err_o}, 32'h0);

        // 32-bit instruction at an aligned target
        branch(32'h80);
        push(32'h00B50533, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Two compressed instructions in one word
        branch(32'h0);
        push(32'h45014581, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Straddling 32-bit instruction from a halfword target
        branch(32'h102);
        push(32'h0533AAAA, 1'b0, 1'b0);
        idle(1'b0);
        push(32'h123400B5, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Fill to full with consumer stalled, then release
        branch(32'h0);
        push(32'h00000013, 1'b0, 1'b0);
        push(32'h00100093, 1'b0, 1'b0);
        push(32'h00200113, 1'b0, 1'b0);
        push(32'h00300193, 1'b0, 1'b0);
        push(32'h00300193, 1'b0, 1'b0);
        push(32'h00300193, 1'b0, 1'b1);
        push(32'h00300193, 1'b0, 1'b0);
        repeat (5) idle(1'b1);

        // Branch wins over simultaneous push and pop
        branch(32'h0);
        push(32'h00000013, 1'b0, 1'b0);
        push(32'h00100093, 1'b0, 1'b0);
        step(1'b1, 32'h00200113, 1'b0, 1'b1, 32'h201, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Bus errors: straddle with erroneous second word, then error at hw0
        branch(32'h2);
        push(32'h0003AAAA, 1'b0, 1'b0);
        idle(1'b1);
        push(32'h00000000, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        branch(32'h10);
        push(32'hFFFFFFFF, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 4) != 0, $urandom, ($urandom % 16) == 0,
                 ($urandom % 40) == 0, $urandom & 32'h0000_0FFF, ($urandom % 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
